// File: rtl/vmul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vmul_sequencer_if
//  Description : Bundle of the request, response and multiplier-side signals
//                of the vector multiply sequencer.
//                slave  - sequencer view (drives req_ready, mul_*, resp_*)
//                master - surrounding view (issue stage, multiplier, consumer)
//  Ports       : req_valid/req_ready/req_sew/req_vl/req_vs1/req_vs2  request
//                mul_start/mul_sew/mul_a/mul_b                       to multiplier
//                mul_done/mul_prod_lo/mul_prod_hi                    from multiplier
//                resp_valid/resp_ready/resp_lo/resp_hi/resp_err      response
//  Revision    : 1.0 - initial release
// ============================================================================
interface vmul_sequencer_if #(
  parameter int VLEN = 128
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_sew;
  logic [7:0]      req_vl;
  logic [VLEN-1:0] req_vs1;
  logic [VLEN-1:0] req_vs2;

  logic            mul_start;
  logic [1:0]      mul_sew;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_done;
  logic [31:0]     mul_prod_lo;
  logic [31:0]     mul_prod_hi;

  logic            resp_valid;
  logic            resp_ready;
  logic [VLEN-1:0] resp_lo;
  logic [VLEN-1:0] resp_hi;
  logic            resp_err;

  modport slave (
    input  req_valid, req_sew, req_vl, req_vs1, req_vs2,
    input  mul_done, mul_prod_lo, mul_prod_hi,
    input  resp_ready,
    output req_ready,
    output mul_start, mul_sew, mul_a, mul_b,
    output resp_valid, resp_lo, resp_hi, resp_err
  );

  modport master (
    output req_valid, req_sew, req_vl, req_vs1, req_vs2,
    output mul_done, mul_prod_lo, mul_prod_hi,
    output resp_ready,
    input  req_ready,
    input  mul_start, mul_sew, mul_a, mul_b,
    input  resp_valid, resp_lo, resp_hi, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/vmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vmul_sequencer
//  Description : Walks one VLEN-bit vector multiply through a shared 32-bit
//                SEW-configurable multi-cycle multiplier, one 32-bit chunk per
//                start/done exchange, collecting low/high product halves into
//                VLEN-bit result buffers returned over a valid/ready response.
//  Ports       : clk    - clock
//                reset  - asynchronous, active-low reset
//                bus    - vmul_sequencer_if.slave (request, multiplier,
//                         response signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module vmul_sequencer #(
  parameter int VLEN    = 128,
  parameter int TIMEOUT = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  vmul_sequencer_if.slave    bus
);

  localparam int NCHUNK = VLEN / 32;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [1:0]      r_sew;
  logic [VLEN-1:0] r_vs1;
  logic [VLEN-1:0] r_vs2;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_last;     // index of the final active chunk
  logic [TW-1:0]   r_timer;
  logic [VLEN-1:0] r_lo;
  logic [VLEN-1:0] r_hi;
  logic            r_err;

  // Active chunk count. Elements per chunk is a power of two, so the
  // ceiling division reduces to add-then-shift.
  logic [1:0]      w_shift;
  logic [15:0]     w_epc;
  logic [15:0]     w_cap;
  logic [15:0]     w_vl;
  logic [15:0]     w_vlc;
  logic [15:0]     w_nact;
  logic [IW-1:0]   w_last;
  logic            w_sew_bad;

  always_comb begin
    w_shift = 2'd0;
    case (bus.req_sew)
      2'b00:   w_shift = 2'd2;
      2'b01:   w_shift = 2'd1;
      default: w_shift = 2'd0;
    endcase
  end

  assign w_epc     = 16'd1 << w_shift;
  assign w_cap     = 16'(NCHUNK) << w_shift;
  assign w_vl      = {8'd0, bus.req_vl};
  assign w_vlc     = (w_vl < w_cap) ? w_vl : w_cap;
  assign w_nact    = (w_vlc + w_epc - 16'd1) >> w_shift;
  assign w_last    = IW'(w_nact - 16'd1);
  assign w_sew_bad = (bus.req_sew == 2'b11);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_sew_bad || (w_vlc == 16'd0)) w_state_nxt = S_RESP;
          else                               w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // A done arriving on the last timer cycle still counts.
        if (bus.mul_done) begin
          if (r_idx == r_last) w_state_nxt = S_RESP;
          else                 w_state_nxt = S_ISSUE;
        end else if (r_timer == TLAST) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Captured operands, chunk index, timer and result buffers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sew   <= 2'd0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_timer <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_sew  <= bus.req_sew;
            r_vs1  <= bus.req_vs1;
            r_vs2  <= bus.req_vs2;
            r_idx  <= '0;
            r_last <= w_last;
            r_lo   <= '0;
            r_hi   <= '0;
            r_err  <= w_sew_bad;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (bus.mul_done) begin
            for (int c = 0; c < NCHUNK; c++) begin
              if (r_idx == IW'(c)) begin
                r_lo[32*c +: 32] <= bus.mul_prod_lo;
                r_hi[32*c +: 32] <= bus.mul_prod_hi;
              end
            end
            if (r_idx != r_last) r_idx <= r_idx + 1'b1;
          end else if (r_timer == TLAST) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Chunk select for the multiplier operands; r_idx and the captured vectors
  // only change in IDLE or on the WAIT->ISSUE edge, so these stay stable
  // across each ISSUE/WAIT pair.
  logic [31:0] w_a;
  logic [31:0] w_b;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_idx == IW'(c)) begin
        w_a = r_vs1[32*c +: 32];
        w_b = r_vs2[32*c +: 32];
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.mul_start  = (r_state == S_ISSUE);
  assign bus.mul_sew    = r_sew;
  assign bus.mul_a      = w_a;
  assign bus.mul_b      = w_b;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_lo    = r_lo;
  assign bus.resp_hi    = r_hi;
  assign bus.resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmul_sequencer
//  Description : Self-checking bench for vmul_sequencer with a behavioural
//                multi-cycle multiplier model and a vector-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vmul_sequencer;

  localparam int VLEN    = 128;
  localparam int NCHUNK  = VLEN / 32;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  vmul_sequencer_if #(.VLEN(VLEN)) bus ();

  vmul_sequencer #(.VLEN(VLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Unsigned packed element multiply of one 32-bit chunk
  function automatic void chunk_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sew,
                                    output logic [31:0] lo, output logic [31:0] hi);
    int    ebits;
    longint unsigned mask, ae, be, p;
    ebits = 8 << sew;
    if (ebits > 32) ebits = 32;
    mask = (64'd1 << ebits) - 64'd1;
    lo = '0;
    hi = '0;
    for (int e = 0; e < 32 / ebits; e++) begin
      ae = (longint'(a) >> (e * ebits)) & mask;
      be = (longint'(b) >> (e * ebits)) & mask;
      p  = ae * be;
      lo = lo | 32'((p & mask) << (e * ebits));
      hi = hi | 32'(((p >> ebits) & mask) << (e * ebits));
    end
  endfunction

  function automatic int calc_nact(input logic [1:0] sew, input logic [7:0] vl);
    int epc, vlc;
    if (sew == 2'b11) return 0;
    epc = 4 >> sew;
    vlc = (int'(vl) < NCHUNK * epc) ? int'(vl) : NCHUNK * epc;
    return (vlc + epc - 1) / epc;
  endfunction

  // ---------------- multiplier model ----------------
  int          mul_delay  = 2;
  int          mul_budget = -1;   // dones still to be returned; -1 = unlimited
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [1:0]  q_sew[$];

  initial begin
    logic [31:0] a, b, lo, hi;
    logic [1:0]  s;
    bus.mul_done    = 1'b0;
    bus.mul_prod_lo = '0;
    bus.mul_prod_hi = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        a = bus.mul_a;
        b = bus.mul_b;
        s = bus.mul_sew;
        q_a.push_back(a);
        q_b.push_back(b);
        q_sew.push_back(s);
        if (mul_budget != 0) begin
          if (mul_budget > 0) mul_budget--;
          chunk_mul(a, b, s, lo, hi);
          repeat (mul_delay) @(posedge clk);
          #1;
          bus.mul_done    = 1'b1;
          bus.mul_prod_lo = lo;
          bus.mul_prod_hi = hi;
          @(posedge clk);
          #1;
          bus.mul_done    = 1'b0;
          bus.mul_prod_lo = $urandom;
          bus.mul_prod_hi = $urandom;
        end
      end
    end
  end

  // ---------------- one request/response transaction ----------------
  task automatic run_req(input string tag, input logic [1:0] sew, input logic [7:0] vl,
                         input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                         input int dly, input int budget, input int stall,
                         output logic [VLEN-1:0] got_lo, output logic [VLEN-1:0] got_hi,
                         output logic got_err, output int lat);
    int              nact, ncol, nst;
    logic [VLEN-1:0] elo, ehi;
    logic            eerr;
    logic [31:0]     clo, chi;
    bit              ok, stable;

    nact = calc_nact(sew, vl);
    ncol = (budget < 0) ? nact : ((budget < nact) ? budget : nact);
    nst  = (budget < 0) ? nact : ((budget + 1 < nact) ? budget + 1 : nact);
    elo  = '0;
    ehi  = '0;
    for (int c = 0; c < ncol; c++) begin
      chunk_mul(a[32*c +: 32], b[32*c +: 32], sew, clo, chi);
      elo[32*c +: 32] = clo;
      ehi[32*c +: 32] = chi;
    end
    eerr = (sew == 2'b11) || (ncol < nact);

    mul_delay  = dly;
    mul_budget = budget;
    q_a.delete();
    q_b.delete();
    q_sew.delete();
    got_lo  = '0;
    got_hi  = '0;
    got_err = 1'b0;
    lat     = 0;

    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_sew   = sew;
    bus.req_vl    = vl;
    bus.req_vs1   = a;
    bus.req_vs2   = b;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_req_ready"}, VLEN'(ok), VLEN'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_vs1   = {$urandom, $urandom, $urandom, $urandom};
    bus.req_vs2   = {$urandom, $urandom, $urandom, $urandom};

    ok = 0;
    for (int i = 0; i < TIMEOUT * 8; i++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_resp_valid"}, VLEN'(ok), VLEN'(1));
    got_lo  = bus.resp_lo;
    got_hi  = bus.resp_hi;
    got_err = bus.resp_err;
    chk({tag, "_lo"},  got_lo, elo);
    chk({tag, "_hi"},  got_hi, ehi);
    chk({tag, "_err"}, VLEN'(got_err), VLEN'(eerr));
    chk({tag, "_starts"}, VLEN'(q_a.size()), VLEN'(nst));
    for (int c = 0; c < q_a.size() && c < NCHUNK; c++) begin
      chk({tag, "_mul_ab"}, {q_sew[c], q_b[c], q_a[c]}, {sew, b[32*c +: 32], a[32*c +: 32]});
    end

    stable = 1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_lo !== got_lo || bus.resp_hi !== got_hi ||
          bus.resp_err !== got_err || bus.req_ready !== 1'b0)
        stable = 0;
    end
    chk({tag, "_hold"}, VLEN'(stable), VLEN'(1));

    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_after_resp"}, VLEN'({bus.resp_valid, bus.req_ready}), VLEN'(2'b01));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [VLEN-1:0] glo, ghi, va, vb;
    logic            gerr;
    int              lat;

    bus.req_valid  = 1'b0;
    bus.req_sew    = 2'b00;
    bus.req_vl     = 8'd0;
    bus.req_vs1    = '0;
    bus.req_vs2    = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", VLEN'({bus.req_ready, bus.mul_start, bus.resp_valid, bus.resp_err, bus.mul_sew}),
        VLEN'(6'b100000));
    chk("rst_data", bus.resp_lo | bus.resp_hi | VLEN'({bus.mul_a, bus.mul_b}), '0);
    @(negedge clk);
    reset = 1'b1;

    // sew=16, vl=2, 3-cycle multiplier
    va = VLEN'(32'h01234567);
    vb = VLEN'(32'h89ABCDEF);
    run_req("t_sew16", 2'b01, 8'd2, va, vb, 3, -1, 2, glo, ghi, gerr, lat);
    chk("t_sew16_lo_const", glo, VLEN'(32'h7D614629));
    chk("t_sew16_hi_const", ghi, VLEN'(32'h009C37D4));
    chk("t_sew16_latency", VLEN'(lat), VLEN'(5));

    // sew=8, vl=5 -> two chunks
    va = {$urandom, $urandom, $urandom, $urandom};
    vb = {$urandom, $urandom, $urandom, $urandom};
    run_req("t_sew8_vl5", 2'b00, 8'd5, va, vb, 2, -1, 0, glo, ghi, gerr, lat);
    chk("t_sew8_vl5_upper", glo[VLEN-1:64] | ghi[VLEN-1:64], '0);

    // sew=32, vl=200 clamps to all four chunks
    run_req("t_sew32_clamp", 2'b10, 8'd200, va, vb, 1, -1, 1, glo, ghi, gerr, lat);

    // zero length and illegal sew
    run_req("t_vl0", 2'b00, 8'd0, va, vb, 2, -1, 0, glo, ghi, gerr, lat);
    chk("t_vl0_fast", VLEN'(lat <= 2), VLEN'(1));
    run_req("t_sew11", 2'b11, 8'd8, va, vb, 2, -1, 0, glo, ghi, gerr, lat);
    chk("t_sew11_fast", VLEN'(lat <= 2), VLEN'(1));

    // multiplier never answers; response held for 10 cycles
    run_req("t_timeout", 2'b10, 8'd4, va, vb, 2, 0, 10, glo, ghi, gerr, lat);
    chk("t_timeout_latency", VLEN'(lat), VLEN'(TIMEOUT + 2));

    // first chunk answered, second times out; collected chunk kept
    run_req("t_partial", 2'b10, 8'd4, va, vb, 2, 1, 0, glo, ghi, gerr, lat);

    // reset during WAIT, late done ignored
    mul_delay  = 8;
    mul_budget = -1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_sew   = 2'b10;
    bus.req_vl    = 8'd4;
    bus.req_vs1   = va;
    bus.req_vs2   = vb;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", VLEN'({bus.req_ready, bus.mul_start, bus.resp_valid, bus.resp_err, bus.mul_sew}),
        VLEN'(6'b100000));
    chk("rst_mid_data", bus.resp_lo | bus.resp_hi | VLEN'({bus.mul_a, bus.mul_b}), '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_late_done", VLEN'({bus.resp_valid, bus.req_ready, bus.mul_start}), VLEN'(3'b010));
    run_req("t_after_rst", 2'b01, 8'd7, va, vb, 2, -1, 0, glo, ghi, gerr, lat);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      logic [1:0] s;
      logic [7:0] vl;
      int         r;
      r  = $urandom_range(0, 9);
      s  = (r == 9) ? 2'b11 : 2'(r % 3);
      vl = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      va = {$urandom, $urandom, $urandom, $urandom};
      vb = {$urandom, $urandom, $urandom, $urandom};
      run_req("t_rand", s, vl, va, vb, $urandom_range(1, 4), -1, $urandom_range(0, 3),
              glo, ghi, gerr, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
